// File: rtl/cim_mem_arbiter_if.sv
// Client-side request/response bundle between the CiM access sources and one bank arbiter.
// Requests are packed per client; grants and read responses come back one-hot.
interface cim_mem_arbiter_if #(
    parameter int N_CLIENTS = 6,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16
);
    logic [N_CLIENTS-1:0]        req_valid;
    logic [N_CLIENTS-1:0]        req_write;
    logic [N_CLIENTS-1:0]        req_lock;
    logic [N_CLIENTS*ADDR_W-1:0] req_addr;
    logic [N_CLIENTS*DATA_W-1:0] req_wdata;
    logic [N_CLIENTS-1:0]        req_ready;
    logic [N_CLIENTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_data;

    modport master (
        output req_valid, req_write, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cim_mem_arbiter.sv
// Single-port bank arbiter: starvation > lock > fixed priority, one grant per cycle, 0-cycle grant.
// Reads answer one cycle after grant; ungranted clients simply hold their request (no queueing).
module cim_mem_arbiter #(
    parameter int                   N_CLIENTS     = 6,
    parameter int                   ADDR_W        = 10,
    parameter int                   DATA_W        = 16,
    parameter logic [N_CLIENTS-1:0] WRITE_EN_MASK = 6'b111011,
    parameter int                   STARVE_LIMIT  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cim_mem_arbiter_if.slave     bus,
    output logic [N_CLIENTS-1:0] mem_read_req_src,
    output logic [N_CLIENTS-1:0] mem_write_req_src,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_read_data,
    output logic                 err_illegal_write,
    output logic [2:0]           err_client
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    logic [N_CLIENTS-1:0] illegal;
    logic [N_CLIENTS-1:0] eligible;
    logic [N_CLIENTS-1:0] starved;
    logic [N_CLIENTS-1:0] grant;
    logic [CW-1:0]        wait_cnt [N_CLIENTS];
    logic                 lock_vld;
    logic [IW-1:0]        lock_idx;
    logic                 win_vld;
    logic [IW-1:0]        win_idx;
    logic [IW-1:0]        ill_idx;
    logic [N_CLIENTS-1:0] rd_owner;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;

    always_comb begin
        illegal  = bus.req_valid & bus.req_write & ~WRITE_EN_MASK;
        eligible = bus.req_valid & ~illegal;
        for (int i = 0; i < N_CLIENTS; i++) begin
            starved[i] = eligible[i] && (wait_cnt[i] == CW'(STARVE_LIMIT));
        end
    end

    // Descending loops leave the lowest matching index in the result.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        if (rst_n) begin
            if (|starved) begin
                win_vld = 1'b1;
                for (int i = N_CLIENTS - 1; i >= 0; i--) begin
                    if (starved[i]) win_idx = IW'(i);
                end
            end else if (lock_vld && eligible[lock_idx]) begin
                win_vld = 1'b1;
                win_idx = lock_idx;
            end else if (|eligible) begin
                win_vld = 1'b1;
                for (int i = N_CLIENTS - 1; i >= 0; i--) begin
                    if (eligible[i]) win_idx = IW'(i);
                end
            end
        end
    end

    always_comb begin
        ill_idx = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (illegal[i]) ill_idx = IW'(i);
        end
    end

    always_comb begin
        grant     = '0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (win_vld) begin
            grant     = N_CLIENTS'(1) << win_idx;
            mem_addr  = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata = bus.req_wdata[win_idx*DATA_W +: DATA_W];
        end
    end

    assign bus.req_ready       = grant;
    assign mem_write_req_src   = grant & bus.req_write;
    assign mem_read_req_src    = grant & ~bus.req_write;
    assign bus.rsp_valid       = rd_owner;
    assign bus.rsp_data        = mem_read_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                wait_cnt[i] <= '0;
            end
            lock_vld          <= 1'b0;
            lock_idx          <= '0;
            rd_owner          <= '0;
            addr_q            <= '0;
            wdata_q           <= '0;
            err_illegal_write <= 1'b0;
            err_client        <= 3'd0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (grant[i] || !eligible[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != CW'(STARVE_LIMIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
            // Any grant without req_lock, including a starvation grant, drops the lock.
            lock_vld <= win_vld && bus.req_lock[win_idx];
            lock_idx <= win_idx;
            rd_owner <= grant & ~bus.req_write;
            if (win_vld) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (|illegal) begin
                err_illegal_write <= 1'b1;
                if (!err_illegal_write) err_client <= 3'(ill_idx);
            end
        end
    end
endmodule

// File: tb/tb_cim_mem_arbiter.sv
// Randomized and directed bench for cim_mem_arbiter with a queue-based read scoreboard.
module tb_cim_mem_arbiter;
    localparam int N  = 6;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int SL = 8;
    localparam logic [N-1:0] MASK = 6'b111011;

    typedef struct packed {
        int            due;
        int            client;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cim_mem_arbiter_if #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    logic [N-1:0]  mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, bank_rd;
    logic          err_flag;
    logic [2:0]    err_cl;

    cim_mem_arbiter #(
        .N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .WRITE_EN_MASK(MASK), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mem_read_req_src(mem_rd), .mem_write_req_src(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_data(bank_rd),
        .err_illegal_write(err_flag), .err_client(err_cl)
    );

    // Bank with a registered read port.
    logic [DW-1:0] bank [1024];
    always @(posedge clk) begin
        if (|mem_rd) bank_rd <= bank[mem_addr];
        if (|mem_wr) bank[mem_addr] = mem_wdata;
    end

    // Client request state and reference model state.
    bit            pv [N], pw [N], pl [N], hold [N];
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    int            rwait [N], age [N];
    int            rlock = -1;
    bit            ref_err = 1'b0;
    int            ref_errc = 0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic [DW-1:0] ref_mem [1024];
    rsp_t          expq [$];

    int cyc = 0, n_checks = 0, n_fail = 0, granted = -1;
    bit rand_mode = 1'b0;
    logic [N-1:0]  obs_ready, obs_wr, obs_rspv;
    logic [DW-1:0] obs_rspd;
    logic          obs_err;
    logic [2:0]    obs_errc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]             = pv[i];
            bus.req_write[i]             = pw[i];
            bus.req_lock[i]              = pl[i];
            bus.req_addr[i*AW +: AW]     = pa[i];
            bus.req_wdata[i*DW +: DW]    = pd[i];
        end
    endtask

    task automatic set_req(input int i, input bit w, input bit l, input int a, input logic [DW-1:0] d);
        pv[i] = 1'b1; pw[i] = w; pl[i] = l; pa[i] = AW'(a); pd[i] = d;
        apply();
    endtask

    // Reference arbitration for the current cycle, evaluated away from the clock edge.
    task automatic eval_cycle();
        int            win;
        logic [N-1:0]  elig, ill, exp_g;
        rsp_t          e;
        obs_ready = bus.req_ready; obs_wr = mem_wr; obs_rspv = bus.rsp_valid;
        obs_rspd  = bus.rsp_data;  obs_err = err_flag; obs_errc = err_cl;
        chk("err_illegal_write", {31'd0, err_flag}, {31'd0, ref_err});
        chk("err_client", {29'd0, err_cl}, ref_errc);
        win = -1;
        for (int i = 0; i < N; i++) begin
            ill[i]  = pv[i] && pw[i] && !MASK[i];
            elig[i] = pv[i] && !ill[i];
        end
        if (rst_n) begin
            for (int i = 0; i < N; i++) if (win < 0 && elig[i] && rwait[i] == SL) win = i;
            if (win < 0 && rlock >= 0 && elig[rlock]) win = rlock;
            for (int i = 0; i < N; i++) if (win < 0 && elig[i]) win = i;
        end
        exp_g = (win >= 0) ? (N'(1) << win) : '0;
        chk("req_ready", {26'd0, bus.req_ready}, {26'd0, exp_g});
        chk("mem_write_req_src", {26'd0, mem_wr}, {26'd0, (win >= 0 && pw[win]) ? exp_g : 6'd0});
        chk("mem_read_req_src", {26'd0, mem_rd}, {26'd0, (win >= 0 && !pw[win]) ? exp_g : 6'd0});
        if (win >= 0) begin
            h_addr  = pa[win];
            h_wdata = pd[win];
        end
        chk("mem_addr", {22'd0, mem_addr}, {22'd0, h_addr});
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, h_wdata});
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin rwait[i] = 0; age[i] = 0; end
            rlock = -1; ref_err = 1'b0; ref_errc = 0; h_addr = '0; h_wdata = '0;
        end else begin
            if (win >= 0) begin
                if (pw[win]) ref_mem[pa[win]] = pd[win];
                else begin
                    e.due = cyc + 1; e.client = win; e.data = ref_mem[pa[win]];
                    expq.push_back(e);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (i == win) begin
                    chk("max_wait_bound", {31'd0, age[i] <= SL + N}, 32'd1);
                    age[i] = 0;
                end else if (elig[i]) age[i]++;
                else age[i] = 0;
                rwait[i] = (elig[i] && i != win) ? ((rwait[i] < SL) ? rwait[i] + 1 : SL) : 0;
            end
            rlock = (win >= 0 && pl[win]) ? win : -1;
            for (int i = 0; i < N; i++) begin
                if (!ref_err && ill[i]) begin ref_err = 1'b1; ref_errc = i; end
            end
        end
        granted = rst_n ? win : -1;
    endtask

    task automatic tick();
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
        if (granted >= 0 && !hold[granted]) pv[granted] = 1'b0;
        if (rand_mode) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                if (pv[i] && granted != i) begin
                    if ($urandom_range(0, 19) == 0) pv[i] = 1'b0;
                end else if (!pv[i] && $urandom_range(0, 99) < 35) begin
                    pv[i] = 1'b1;
                    pw[i] = (i == 2) ? ($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 1));
                    pl[i] = ($urandom_range(0, 3) == 0);
                    pa[i] = AW'($urandom_range(0, 15));
                    pd[i] = DW'($urandom);
                end
            end
        end
        apply();
    endtask

    // Response monitor: pops the scoreboard whenever a response is due.
    always @(negedge clk) begin
        rsp_t e;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            chk("rsp_valid", {26'd0, bus.rsp_valid}, {26'd0, N'(1) << e.client});
            chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, e.data});
        end else begin
            chk("rsp_valid_idle", {26'd0, bus.rsp_valid}, 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bank[i]    = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        for (int i = 0; i < N; i++) begin
            pv[i] = 0; pw[i] = 0; pl[i] = 0; hold[i] = 0; pa[i] = '0; pd[i] = '0;
            rwait[i] = 0; age[i] = 0;
        end
        apply();
        rst_n = 1'b0;
        tick();
        chk("reset_ready", {26'd0, obs_ready}, 32'd0);
        chk("reset_rsp_valid", {26'd0, obs_rspv}, 32'd0);
        chk("reset_err", {31'd0, obs_err}, 32'd0);
        chk("reset_mem_addr", {22'd0, mem_addr}, 32'd0);
        rst_n = 1'b1;

        // Illegal MAC write alongside a legal write from client 4.
        set_req(2, 1, 0, 5, 16'h1111);
        set_req(4, 1, 0, 7, 16'h2222);
        tick();
        chk("illegal_ready", {26'd0, obs_ready}, 32'b010000);
        chk("illegal_wstrobe", {26'd0, obs_wr}, 32'b010000);
        tick();
        chk("illegal_no_grant", {26'd0, obs_ready}, 32'd0);
        chk("illegal_err_flag", {31'd0, obs_err}, 32'd1);
        chk("illegal_err_client", {29'd0, obs_errc}, 32'd2);
        pv[2] = 0; apply();

        // Simultaneous reads from clients 1, 3, 5.
        set_req(1, 0, 0, 40, '0);
        set_req(3, 0, 0, 41, '0);
        set_req(5, 0, 0, 42, '0);
        tick();
        chk("simul_grant1", {26'd0, obs_ready}, 32'b000010);
        tick();
        chk("simul_grant3", {26'd0, obs_ready}, 32'b001000);
        chk("simul_rsp1", {26'd0, obs_rspv}, 32'b000010);
        chk("simul_rsp1_data", {16'd0, obs_rspd}, 40 * 7 + 3);
        tick();
        chk("simul_grant5", {26'd0, obs_ready}, 32'b100000);
        chk("simul_rsp3", {26'd0, obs_rspv}, 32'b001000);
        tick();
        chk("simul_rsp5", {26'd0, obs_rspv}, 32'b100000);

        // Lock hold: client 3 keeps the bank for 4 cycles against client 1.
        set_req(3, 0, 1, 20, '0);
        hold[3] = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) set_req(1, 0, 0, 21, '0);
            if (k == 3) hold[3] = 0;
            tick();
            chk("lock_seq", {26'd0, obs_ready}, (k < 4) ? 32'b001000 : 32'b000010);
        end
        tick();

        // Starvation: client 0 hogs, client 4 wins at the limit.
        hold[0] = 1;
        set_req(0, 0, 0, 1, '0);
        set_req(4, 0, 0, 2, '0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("starve_seq", {26'd0, obs_ready}, (k == SL) ? 32'b010000 : 32'b000001);
            if (k == SL) chk("starve_wait_clear", {28'd0, dut.wait_cnt[4]}, 32'd0);
        end
        hold[0] = 0; pv[0] = 0; apply();
        tick();

        // Write then read of the same address.
        set_req(0, 1, 0, 10, 16'hBEEF);
        tick();
        chk("rt_write_strobe", {26'd0, obs_wr}, 32'b000001);
        set_req(0, 0, 0, 10, '0);
        tick();
        tick();
        chk("rt_rsp_valid", {26'd0, obs_rspv}, 32'b000001);
        chk("rt_rsp_data", {16'd0, obs_rspd}, 32'h0000BEEF);

        // Reset while a read is requested, with a lock in place.
        set_req(3, 0, 1, 3, '0);
        tick();
        set_req(1, 0, 0, 4, '0);
        set_req(3, 0, 0, 5, '0);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_no_grant", {26'd0, obs_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_mid_no_rsp", {26'd0, obs_rspv}, 32'd0);
        chk("rst_mid_lock_cleared", {26'd0, obs_ready}, 32'b000010);
        chk("rst_mid_err_cleared", {31'd0, obs_err}, 32'd0);
        tick();
        tick();

        // Random traffic against the reference model.
        rand_mode = 1'b1;
        repeat (4000) tick();
        rand_mode = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin pv[i] = 0; hold[i] = 0; end
        apply();
        repeat (3) tick();
        chk("queue_drained", expq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cim_mem_arbiter.md
# cim_mem_arbiter

Single-port memory arbiter for one CiM memory bank (intermediate results or params). It sits directly upstream of the bank: it takes read/write requests from the six CiM access sources and grants at most one per cycle. It drives the bank's one-hot `read_req_src`/`write_req_src`, address table and write data, and routes the 1-cycle-late read data back to the granted reader. One instance is used per bank.

## Interface
Parameters:
- `N_CLIENTS`, 6: request sources. Index order (priority, 0 highest): 0 BUS_FSM, 1 LOGIC_FSM, 2 MAC, 3 LAYERNORM, 4 DATA_FILL_FSM, 5 DENSE_BROADCAST_SAVE_FSM.
- `ADDR_W`, 10: bank address width.
- `DATA_W`, 16: word width (N_STORAGE).
- `WRITE_EN_MASK`, 6'b111011: bit i = 1 means client i may write. MAC (bit 2) is read-only.
- `STARVE_LIMIT`, 8: wait cycles before a requester is marked starved (≥1).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in N_CLIENTS: per-client request.
- `req_write` in N_CLIENTS: 1 = write, 0 = read.
- `req_lock` in N_CLIENTS: request to keep the grant on the next cycle.
- `req_addr` in N_CLIENTS*ADDR_W: packed; client i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata` in N_CLIENTS*DATA_W: packed, same layout.
- `req_ready` out N_CLIENTS: one-hot grant. The request is accepted this cycle.
- `rsp_valid` out N_CLIENTS: one-hot; read data is valid for that client.
- `rsp_data` out DATA_W: read data, shared by all clients.
- `mem_read_req_src` out N_CLIENTS: one-hot read strobe to the bank.
- `mem_write_req_src` out N_CLIENTS: one-hot write strobe to the bank.
- `mem_addr` out ADDR_W: granted address.
- `mem_wdata` out DATA_W: granted write data.
- `mem_read_data` in DATA_W: bank registered read output.
- `err_illegal_write` out 1: sticky. Set when a client masked in `WRITE_EN_MASK` requests a write.
- `err_client` out 3: index of the first illegal writer.

## Operation
- **Eligibility.** Client i is eligible when `req_valid[i]` is set, and it is not the case that `req_write[i]=1` with `WRITE_EN_MASK[i]=0`.
  - An illegal writer is never granted.
  - It sets `err_illegal_write`. `err_client` latches on the first occurrence only.
- **Grant selection** (combinational, evaluated in this order):
  1. **Starved.** If any eligible client has `wait_cnt == STARVE_LIMIT`, the lowest such index wins.
  2. **Lock.** Otherwise, if `lock_owner` is valid and that client is eligible, it wins.
  3. **Fixed priority.** Otherwise, the lowest eligible index wins.
  4. **None.** If no client is eligible, there is no grant.
- **Grant outputs.** `req_ready` is one-hot of the winner, and all zeros when there is none.
  - `mem_read_req_src` or `mem_write_req_src` carries the same one-hot, chosen by `req_write`.
  - The other strobe vector is all zeros. At most one bit is set across both vectors.
- **Address/data mux.** `mem_addr` and `mem_wdata` take the winner's slice. With no grant they hold their previous values (registered mux).
- **Per-client wait counter** (`wait_cnt[i]`, saturating at `STARVE_LIMIT`):
  - +1 when eligible and not granted.
  - Cleared when granted or when not eligible.
- **Lock register.** On a grant with `req_lock[winner]=1`, `lock_owner` is set to the winner. Otherwise it is cleared.
  - A starvation grant to another client also breaks the lock.
- **Read tracking.** Register `rd_owner`, a one-hot of the read grant (zeros for writes and idle cycles).
  - `rsp_valid = rd_owner`.
  - `rsp_data = mem_read_data` (pass-through).

## Timing
- **Reset** (`rst_n=0` sampled at a clk edge) clears:
  - `rsp_valid` to 0, `rd_owner` to 0, `lock_owner` to invalid, all `wait_cnt` to 0.
  - `err_illegal_write` to 0 and `err_client` to 0.
  - `mem_addr` and `mem_wdata` to 0.
  - `req_ready` and the mem strobes are 0 while reset is held.
- **Reset mid-operation.** A read granted in the cycle reset is sampled produces no `rsp_valid`.
- **Grant latency.** 0 cycles: `req_ready` and the mem strobes are combinational from the requests, current `wait_cnt` and `lock_owner`.
  - `mem_addr` and `mem_wdata` are combinational from the winner when a grant exists.
- **Write.** Completes at the clock edge ending the grant cycle T.
- **Read.** Granted in cycle T; `rsp_valid` and `rsp_data` are valid in T+1 for exactly one cycle.
  - Back-to-back reads from the same or different clients give one response per cycle, in grant order.
- **Handshake.** A client holds `req_valid`, `req_write`, `req_addr` and `req_wdata` stable until it sees `req_ready`. Dropping a request without a grant is allowed and clears its `wait_cnt`.
- **Write then read, same address.** Write in T and read in T+1 returns the new data in T+2.
- **Maximum wait.** An eligible client is granted within `STARVE_LIMIT+N_CLIENTS` cycles.

## Test plan
- **Simultaneous requests.** Reads from clients 1, 3 and 5 in the same cycle: `req_ready=6'b000010`, and client 1's `rsp_valid` follows at T+1 with the bank data at its address. Clients 3 and 5 are then served in order over the next 2 cycles.
- **Lock hold.** Client 3 (LAYERNORM) reads with `req_lock=1` for 4 cycles while client 1 requests continuously: client 3 is granted 4 consecutive cycles, then client 1.
- **Starvation override.** Client 0 requests continuously and client 4 requests from cycle 0 with `STARVE_LIMIT=8`: client 4 is granted at cycle 8 for one cycle, and `wait_cnt[4]` returns to 0.
- **Illegal MAC write.** Client 2 write with addr 5: never granted, no strobes, `err_illegal_write=1` and `err_client=2` from the next cycle. A concurrent client 4 write is still granted.
- **Write/read round trip.** Client 0 writes 16'hBEEF to addr 10 in T, client 0 reads addr 10 in T+1: `rsp_valid[0]=1` and `rsp_data=16'hBEEF` in T+2.
- **Reset during a read.** `rst_n` is low in the cycle of a read grant: no `rsp_valid` afterwards, and all counters and the lock are cleared.
